// File: rtl/bscan_dmi_bridge.sv
// BSCAN user-chain to DMI bridge: oversamples TCK in the clk_i domain and turns UPDATE into DMI transactions.
// Optional response timeout enabled by defining BSCAN_DMI_TIMEOUT_EN.
module bscan_dmi_bridge #(
    parameter int ABITS          = 7,
    parameter int SYNC_STAGES    = 2,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             tck_i,
    input  logic             tdi_i,
    input  logic             sel_i,
    input  logic             shift_i,
    input  logic             capture_i,
    input  logic             update_i,
    input  logic             tap_reset_i,
    output logic             tdo_o,
    output logic             dmi_req_valid_o,
    input  logic             dmi_req_ready_i,
    output logic [ABITS-1:0] dmi_req_addr_o,
    output logic [31:0]      dmi_req_data_o,
    output logic [1:0]       dmi_req_op_o,
    input  logic             dmi_resp_valid_i,
    output logic             dmi_resp_ready_o,
    input  logic [31:0]      dmi_resp_data_i,
    input  logic [1:0]       dmi_resp_resp_i
);

    localparam int DW = ABITS + 34;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        REQ      = 2'd1,
        WAIT_RSP = 2'd2
    } state_t;

    state_t state, state_next;

    logic [SYNC_STAGES-1:0][6:0] sync_q;
    logic tck_s, tdi_s, sel_s, shift_s, capture_s, update_s, trst_s;
    logic tck_prev;
    logic tck_rise, tck_fall;

    logic [DW-1:0]    sr;
    logic [ABITS-1:0] last_addr;
    logic [31:0]      rdata;
    logic [1:0]       sticky;
    logic [1:0]       status;
    logic [ABITS-1:0] req_addr;
    logic [31:0]      req_data;
    logic [1:0]       req_op;

    logic [1:0]       upd_op;
    logic [31:0]      upd_data;
    logic [ABITS-1:0] upd_addr;
    logic busy, do_capture, do_shift, do_update, accept, reject, cap_busy;
    logic resp_done, rsp_fail, tmo_hit, tmo_fire;

    // All BSCAN signals share one synchronizer chain so they stay mutually aligned.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync_q   <= '0;
            tck_prev <= 1'b0;
        end else begin
            sync_q   <= {sync_q[SYNC_STAGES-2:0],
                         {tap_reset_i, update_i, capture_i, shift_i, sel_i, tdi_i, tck_i}};
            tck_prev <= tck_s;
        end
    end

    assign {trst_s, update_s, capture_s, shift_s, sel_s, tdi_s, tck_s} = sync_q[SYNC_STAGES-1];
    assign tck_rise = tck_s & ~tck_prev;
    assign tck_fall = ~tck_s & tck_prev;

    assign upd_op   = sr[1:0];
    assign upd_data = sr[33:2];
    assign upd_addr = sr[DW-1:34];

    assign busy       = (state != IDLE);
    assign status     = (sticky != 2'd0) ? sticky : (busy ? 2'd3 : 2'd0);
    assign do_capture = tck_rise & sel_s & capture_s & ~trst_s;
    assign do_shift   = tck_rise & sel_s & shift_s & ~capture_s & ~trst_s;
    assign do_update  = tck_rise & sel_s & update_s & ~trst_s &
                        ((upd_op == 2'd1) | (upd_op == 2'd2));
    assign accept     = do_update & ~busy & (sticky == 2'd0);
    assign reject     = do_update & (busy | (sticky != 2'd0));
    assign cap_busy   = do_capture & busy;
    assign resp_done  = (state == WAIT_RSP) & dmi_resp_valid_i;
    assign rsp_fail   = resp_done & (dmi_resp_resp_i != 2'd0);

`ifdef BSCAN_DMI_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 2);
    logic [CW-1:0] tmo_cnt;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            tmo_cnt <= '0;
        end else if (accept) begin
            tmo_cnt <= '0;
        end else if (busy) begin
            tmo_cnt <= tmo_cnt + CW'(1);
        end
    end

    assign tmo_hit = busy & (tmo_cnt >= CW'(TIMEOUT_CYCLES - 1));
`else
    logic unused_cfg;
    assign unused_cfg = |TIMEOUT_CYCLES;
    assign tmo_hit    = 1'b0;
`endif

    // A handshake that lands in the timeout cycle still completes normally.
    assign tmo_fire = tmo_hit & (((state == REQ) & ~dmi_req_ready_i) |
                                 ((state == WAIT_RSP) & ~dmi_resp_valid_i));

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sr    <= '0;
            tdo_o <= 1'b0;
        end else if (trst_s) begin
            sr    <= '0;
            tdo_o <= 1'b0;
        end else begin
            if (do_capture) begin
                sr <= {last_addr, rdata, status};
            end else if (do_shift) begin
                sr <= {tdi_s, sr[DW-1:1]};
            end
            if (tck_fall & sel_s) begin
                tdo_o <= sr[0];
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            last_addr <= '0;
            req_addr  <= '0;
            req_data  <= '0;
            req_op    <= '0;
            rdata     <= '0;
            sticky    <= '0;
        end else begin
            if (accept) begin
                last_addr <= upd_addr;
                req_addr  <= upd_addr;
                req_data  <= upd_data;
                req_op    <= upd_op;
            end
            if (resp_done && (req_op == 2'd1)) begin
                rdata <= dmi_resp_data_i;
            end
            if (trst_s) begin
                sticky <= 2'd0;
            end else if (rsp_fail || tmo_fire) begin
                sticky <= 2'd2;
            end else if (cap_busy || reject) begin
                sticky <= 2'd3;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next       = state;
        dmi_req_valid_o  = 1'b0;
        dmi_resp_ready_o = 1'b0;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_next = REQ;
                end
            end
            REQ: begin
                dmi_req_valid_o = 1'b1;
                if (dmi_req_ready_i) begin
                    state_next = WAIT_RSP;
                end else if (tmo_fire) begin
                    state_next = IDLE;
                end
            end
            WAIT_RSP: begin
                dmi_resp_ready_o = 1'b1;
                if (dmi_resp_valid_i || tmo_fire) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign dmi_req_addr_o = req_addr;
    assign dmi_req_data_o = req_data;
    assign dmi_req_op_o   = req_op;

endmodule

// File: tb/tb_bscan_dmi_bridge.sv
// Self-checking bench for bscan_dmi_bridge: vector table plus hand-written corner sequences.
// Define BSCAN_DMI_TIMEOUT_EN to also exercise the response timeout (TIMEOUT_CYCLES=16).
module tb_bscan_dmi_bridge;

    localparam int ABITS = 7;
    localparam int DW    = ABITS + 34;
    localparam int H     = 6;
`ifdef BSCAN_DMI_TIMEOUT_EN
    localparam int TMO = 16;
`else
    localparam int TMO = 1024;
`endif

    logic clk = 1'b0;
    logic rst_ni;
    logic tck_i, tdi_i, sel_i, shift_i, capture_i, update_i, tap_reset_i;
    logic tdo_o;
    logic dmi_req_valid_o, dmi_req_ready_i;
    logic [ABITS-1:0] dmi_req_addr_o;
    logic [31:0] dmi_req_data_o;
    logic [1:0] dmi_req_op_o;
    logic dmi_resp_valid_i, dmi_resp_ready_o;
    logic [31:0] dmi_resp_data_i;
    logic [1:0] dmi_resp_resp_i;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [ABITS-1:0] addr;
        logic [31:0] data;
        logic [1:0] op;
    } req_t;
    req_t exp_q[$];

    typedef struct {
        logic [ABITS-1:0] addr;
        logic [31:0] data;
        logic [1:0] op;
        logic [31:0] rsp_data;
        logic [1:0] rsp_code;
        int ready_delay;
        bit exp_req;
        logic [ABITS-1:0] cap_addr;
        logic [31:0] cap_rdata;
        logic [1:0] cap_status;
    } vec_t;
    vec_t vecs[6];

    bit ready_enable = 1'b1;
    bit resp_enable = 1'b1;
    int ready_delay = 0;
    logic [31:0] rsp_data = '0;
    logic [1:0] rsp_code = '0;
    bit pending;
    int wait_cnt;
    int valid_run;
    int last_run;

    always #5 clk = ~clk;

    bscan_dmi_bridge #(.ABITS(ABITS), .SYNC_STAGES(2), .TIMEOUT_CYCLES(TMO)) dut (
        .clk_i(clk), .rst_ni(rst_ni),
        .tck_i(tck_i), .tdi_i(tdi_i), .sel_i(sel_i), .shift_i(shift_i),
        .capture_i(capture_i), .update_i(update_i), .tap_reset_i(tap_reset_i),
        .tdo_o(tdo_o),
        .dmi_req_valid_o(dmi_req_valid_o), .dmi_req_ready_i(dmi_req_ready_i),
        .dmi_req_addr_o(dmi_req_addr_o), .dmi_req_data_o(dmi_req_data_o),
        .dmi_req_op_o(dmi_req_op_o),
        .dmi_resp_valid_i(dmi_resp_valid_i), .dmi_resp_ready_o(dmi_resp_ready_o),
        .dmi_resp_data_i(dmi_resp_data_i), .dmi_resp_resp_i(dmi_resp_resp_i)
    );

    task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // DMI responder and request scoreboard; drives at negedge so values are stable at posedge.
    always @(negedge clk) begin
        if (!rst_ni) begin
            dmi_req_ready_i  = 1'b0;
            dmi_resp_valid_i = 1'b0;
            dmi_resp_data_i  = '0;
            dmi_resp_resp_i  = '0;
            pending   = 1'b0;
            wait_cnt  = 0;
            valid_run = 0;
        end else begin
            if (dmi_req_valid_o) begin
                valid_run++;
                if (exp_q.size() == 0) begin
                    if (wait_cnt == 0) begin
                        checks++;
                        errors++;
                        $display("[TB] FAIL unexpected_req: got addr %h op %0d, expected no request",
                                 dmi_req_addr_o, dmi_req_op_o);
                    end
                end else begin
                    check_output("req_addr", 64'(dmi_req_addr_o), 64'(exp_q[0].addr));
                    check_output("req_data", 64'(dmi_req_data_o), 64'(exp_q[0].data));
                    check_output("req_op", 64'(dmi_req_op_o), 64'(exp_q[0].op));
                end
                if (ready_enable && wait_cnt >= ready_delay) begin
                    dmi_req_ready_i = 1'b1;
                    pending  = 1'b1;
                    wait_cnt = 0;
                    if (exp_q.size() != 0) void'(exp_q.pop_front());
                end else begin
                    dmi_req_ready_i = 1'b0;
                    wait_cnt++;
                end
            end else begin
                dmi_req_ready_i = 1'b0;
                wait_cnt = 0;
                if (valid_run != 0) begin
                    last_run  = valid_run;
                    valid_run = 0;
                end
            end
            if (pending && resp_enable && dmi_resp_ready_o) begin
                dmi_resp_valid_i = 1'b1;
                dmi_resp_data_i  = rsp_data;
                dmi_resp_resp_i  = rsp_code;
                pending = 1'b0;
            end else begin
                dmi_resp_valid_i = 1'b0;
            end
        end
    end

    task automatic tck_cycle(input logic tdi, input logic sh, input logic cap, input logic upd,
                             output logic tdo_sample);
        tdi_i = tdi; shift_i = sh; capture_i = cap; update_i = upd;
        repeat (2) @(negedge clk);
        tck_i = 1'b1;
        repeat (H) @(negedge clk);
        tck_i = 1'b0;
        repeat (H) @(negedge clk);
        tdo_sample = tdo_o;
    endtask

    // Optional capture, then DW shifts; dout collects the bits seen on tdo, LSB first.
    task automatic apply_stimulus(input logic [DW-1:0] din, input bit with_capture,
                                  output logic [DW-1:0] dout);
        logic b;
        if (with_capture) begin
            tck_cycle(1'b0, 1'b0, 1'b1, 1'b0, b);
            dout[0] = b;
        end else begin
            dout[0] = tdo_o;
        end
        for (int i = 0; i < DW; i++) begin
            tck_cycle(din[i], 1'b1, 1'b0, 1'b0, b);
            if (i < DW - 1) dout[i+1] = b;
        end
        shift_i = 1'b0; tdi_i = 1'b0;
    endtask

    task automatic pulse_update();
        logic b;
        tck_cycle(1'b0, 1'b0, 1'b0, 1'b1, b);
        update_i = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        bit done = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if (!dmi_req_valid_o && !dmi_resp_ready_o && !pending) begin
                done = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!done) begin
            checks++;
            errors++;
            $display("[TB] FAIL %s: got busy after 400 cycles, expected idle", name);
        end
    endtask

    task automatic pulse_tap_reset();
        tap_reset_i = 1'b1;
        repeat (8) @(negedge clk);
        check_output("tap_reset_tdo", 64'(tdo_o), 64'd0);
        tap_reset_i = 1'b0;
        repeat (8) @(negedge clk);
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: got no finish, expected finish before time limit");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        logic [DW-1:0] dout;
        logic b;

        vecs[0] = '{7'h10, 32'hDEADBEEF, 2'd2, 32'h0,        2'd0, 3, 1'b1, 7'h10, 32'h00000000, 2'd0};
        vecs[1] = '{7'h11, 32'h00000000, 2'd1, 32'h12345678, 2'd0, 0, 1'b1, 7'h11, 32'h12345678, 2'd0};
        vecs[2] = '{7'h22, 32'h11111111, 2'd0, 32'h0,        2'd0, 0, 1'b0, 7'h11, 32'h12345678, 2'd0};
        vecs[3] = '{7'h33, 32'h22222222, 2'd3, 32'h0,        2'd0, 0, 1'b0, 7'h11, 32'h12345678, 2'd0};
        vecs[4] = '{7'h7F, 32'hA5A50F0F, 2'd2, 32'hFFFFFFFF, 2'd0, 0, 1'b1, 7'h7F, 32'h12345678, 2'd0};
        vecs[5] = '{7'h00, 32'h00000000, 2'd1, 32'hCAFEF00D, 2'd0, 0, 1'b1, 7'h00, 32'hCAFEF00D, 2'd0};

        rst_ni = 1'b0;
        tck_i = 0; tdi_i = 0; sel_i = 1; shift_i = 0; capture_i = 0; update_i = 0; tap_reset_i = 0;
        repeat (5) @(negedge clk);
        check_output("rst_tdo", 64'(tdo_o), 64'd0);
        check_output("rst_valid", 64'(dmi_req_valid_o), 64'd0);
        check_output("rst_resp_ready", 64'(dmi_resp_ready_o), 64'd0);
        check_output("rst_payload", {dmi_req_addr_o, dmi_req_data_o, dmi_req_op_o}, 64'd0);
        rst_ni = 1'b1;
        repeat (5) @(negedge clk);
        apply_stimulus('0, 1'b1, dout);
        check_output("rst_capture", 64'(dout), 64'd0);

        for (int i = 0; i < 6; i++) begin
            rsp_data = vecs[i].rsp_data;
            rsp_code = vecs[i].rsp_code;
            ready_delay = vecs[i].ready_delay;
            apply_stimulus({vecs[i].addr, vecs[i].data, vecs[i].op}, 1'b1, dout);
            if (vecs[i].exp_req) exp_q.push_back('{vecs[i].addr, vecs[i].data, vecs[i].op});
            pulse_update();
            wait_idle($sformatf("vec%0d_idle", i));
            if (i == 0) check_output("vec0_valid_len", 64'(last_run), 64'd4);
            apply_stimulus('0, 1'b1, dout);
            check_output($sformatf("vec%0d_capture", i), 64'(dout),
                         64'({vecs[i].cap_addr, vecs[i].cap_rdata, vecs[i].cap_status}));
        end
        ready_delay = 0;
        check_output("sb_empty", 64'(exp_q.size()), 64'd0);

        // Busy: response withheld, capture reports 3 and a second update is dropped.
        resp_enable = 1'b0;
        rsp_code = 2'd0;
        apply_stimulus({7'h20, 32'h0BADF00D, 2'd2}, 1'b1, dout);
        exp_q.push_back('{7'h20, 32'h0BADF00D, 2'd2});
        pulse_update();
        repeat (10) @(negedge clk);
        check_output("busy_resp_ready", 64'(dmi_resp_ready_o), 64'd1);
        apply_stimulus({7'h21, 32'h33333333, 2'd2}, 1'b1, dout);
        check_output("busy_capture", 64'(dout), 64'({7'h20, 32'hCAFEF00D, 2'd3}));
        pulse_update();
        repeat (20) @(negedge clk);
        resp_enable = 1'b1;
        wait_idle("busy_idle");
        apply_stimulus({DW{1'b1}}, 1'b1, dout);
        check_output("busy_sticky", 64'(dout), 64'({7'h20, 32'hCAFEF00D, 2'd3}));
        check_output("busy_tdo_high", 64'(tdo_o), 64'd1);
        pulse_tap_reset();
        apply_stimulus('0, 1'b1, dout);
        check_output("busy_cleared", 64'(dout), 64'({7'h20, 32'hCAFEF00D, 2'd0}));

        // Failed response: sticky 2, later updates blocked until tap reset.
        rsp_code = 2'd2;
        apply_stimulus({7'h30, 32'h12121212, 2'd2}, 1'b1, dout);
        exp_q.push_back('{7'h30, 32'h12121212, 2'd2});
        pulse_update();
        wait_idle("fail_idle");
        rsp_code = 2'd0;
        apply_stimulus({7'h31, 32'h44444444, 2'd2}, 1'b1, dout);
        check_output("fail_capture", 64'(dout), 64'({7'h30, 32'hCAFEF00D, 2'd2}));
        pulse_update();
        repeat (30) @(negedge clk);
        check_output("fail_no_req", 64'(dmi_req_valid_o), 64'd0);
        pulse_tap_reset();
        apply_stimulus({7'h32, 32'h55AA55AA, 2'd2}, 1'b1, dout);
        check_output("fail_cleared", 64'(dout), 64'({7'h30, 32'hCAFEF00D, 2'd0}));
        exp_q.push_back('{7'h32, 32'h55AA55AA, 2'd2});
        pulse_update();
        wait_idle("fail_recover_idle");
        apply_stimulus('0, 1'b1, dout);
        check_output("fail_recover", 64'(dout), 64'({7'h32, 32'hCAFEF00D, 2'd0}));

        // Deselected chain ignores TCK activity entirely.
        apply_stimulus({7'h5A, 32'h13579BDF, 2'd1}, 1'b1, dout);
        sel_i = 1'b0;
        for (int i = 0; i < 12; i++) tck_cycle(1'b0, 1'b1, (i % 4) == 1, (i % 4) == 3, b);
        update_i = 1'b0; capture_i = 1'b0; shift_i = 1'b0;
        check_output("nosel_tdo", 64'(tdo_o), 64'd1);
        check_output("nosel_valid", 64'(dmi_req_valid_o), 64'd0);
        sel_i = 1'b1;
        apply_stimulus('0, 1'b0, dout);
        check_output("nosel_sr", 64'(dout), 64'({7'h5A, 32'h13579BDF, 2'd1}));

        // Reset while a request is pending.
        ready_enable = 1'b0;
        apply_stimulus({7'h40, 32'h0F0F0F0F, 2'd2}, 1'b1, dout);
        exp_q.push_back('{7'h40, 32'h0F0F0F0F, 2'd2});
        pulse_update();
        check_output("rstreq_valid_before", 64'(dmi_req_valid_o), 64'd1);
        rst_ni = 1'b0;
        #1;
        check_output("rstreq_valid", 64'(dmi_req_valid_o), 64'd0);
        check_output("rstreq_payload", {dmi_req_addr_o, dmi_req_data_o, dmi_req_op_o}, 64'd0);
        check_output("rstreq_resp_ready", 64'(dmi_resp_ready_o), 64'd0);
        exp_q.delete();
        repeat (3) @(negedge clk);
        rst_ni = 1'b1;
        ready_enable = 1'b1;
        repeat (30) @(negedge clk);
        check_output("rstreq_stay_idle", 64'(dmi_req_valid_o), 64'd0);
        apply_stimulus('0, 1'b1, dout);
        check_output("rstreq_capture", 64'(dout), 64'd0);

`ifdef BSCAN_DMI_TIMEOUT_EN
        ready_enable = 1'b0;
        apply_stimulus({7'h50, 32'h77777777, 2'd2}, 1'b1, dout);
        exp_q.push_back('{7'h50, 32'h77777777, 2'd2});
        pulse_update();
        repeat (40) @(negedge clk);
        check_output("tmo_valid_len", 64'(last_run), 64'd16);
        check_output("tmo_valid", 64'(dmi_req_valid_o), 64'd0);
        exp_q.delete();
        ready_enable = 1'b1;
        apply_stimulus('0, 1'b1, dout);
        check_output("tmo_capture", 64'(dout), 64'({7'h50, 32'h00000000, 2'd2}));
        pulse_tap_reset();
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/bscan_dmi_bridge.md
Name: bscan_dmi_bridge

Overview:
Consumes the user-chain outputs of the FPGA boundary-scan primitive (TCK/TDI/SEL/SHIFT/CAPTURE/UPDATE/RESET) and feeds its TDO input. It implements a DMI-style data register (addr/data/op) in the system clock domain by oversampling TCK. It converts each UPDATE into one request/response transaction toward the debug module. It sits between the BSCANE2 instance and the debug module's DMI port.

Parameters:
ABITS, 7, DMI address width; shift register width DW = ABITS+34
SYNC_STAGES, 2, synchronizer depth for all BSCAN inputs (min 2)
TIMEOUT_CYCLES, 1024, response timeout in clk_i cycles (used only with the optional feature)

Ports:
clk_i  in  1  system clock; must be >= 4x TCK frequency
rst_ni  in  1  asynchronous active-low reset
tck_i  in  1  BSCAN TCK (treated as data, synchronized)
tdi_i  in  1  BSCAN TDI
sel_i  in  1  BSCAN SEL (user chain selected)
shift_i  in  1  BSCAN SHIFT
capture_i  in  1  BSCAN CAPTURE
update_i  in  1  BSCAN UPDATE
tap_reset_i  in  1  BSCAN RESET (TAP test-logic-reset)
tdo_o  out  1  to BSCAN TDO
dmi_req_valid_o  out  1  request valid
dmi_req_ready_i  in  1  request accepted
dmi_req_addr_o  out  ABITS  request address
dmi_req_data_o  out  32  write data
dmi_req_op_o  out  2  1=read, 2=write
dmi_resp_valid_i  in  1  response valid
dmi_resp_ready_o  out  1  response accept
dmi_resp_data_i  in  32  read data
dmi_resp_resp_i  in  2  0=ok, 2=failed

Behaviour:
- Reset (rst_ni low, async): tdo_o=0, dmi_req_valid_o=0, addr/data/op outputs=0, dmi_resp_ready_o=0, FSM=IDLE, shift reg=0, last_addr=0, rdata=0, sticky status=0.
- All BSCAN inputs pass through the same SYNC_STAGES flops. tck_rise = sync TCK 1 and previous 0; tck_fall is the inverse. The remaining sync inputs are sampled at these edges.
- On tck_rise with sel: capture -> SR = {last_addr, rdata, status}; status occupies SR[1:0]. status = sticky if sticky!=0, else 3 if FSM!=IDLE, else 0. A capture while FSM!=IDLE also sets sticky=3.
- Otherwise, on tck_rise with sel & shift: SR = {tdi, SR[DW-1:1]} (LSB out first).
- On tck_fall with sel: tdo_o <= SR[0], registered, so it changes in the clk cycle the edge is detected. tdo_o holds its value when sel=0.
- On tck_rise with sel & update: op=SR[1:0], data=SR[33:2], addr=SR[DW-1:34].
  - Ignored if op is 0 or 3.
  - Ignored and sticky=3 if FSM!=IDLE or sticky!=0.
  - Otherwise: last_addr=addr, outputs loaded, FSM->REQ.
- FSM:
  - IDLE: no outputs asserted.
  - REQ: dmi_req_valid_o=1; payload is stable until dmi_req_ready_i. Valid&ready -> WAIT_RSP, and valid drops the next cycle.
  - WAIT_RSP: dmi_resp_ready_o=1. On dmi_resp_valid_i: if op was read, rdata=dmi_resp_data_i. If resp!=0, sticky=2. -> IDLE.
- Request latency: dmi_req_valid_o rises 1 clk after the cycle in which the update edge is detected.
- tap_reset_i (synchronized, level): clears sticky and SR, and forces tdo_o=0. It does not abort an in-flight FSM transaction.
- capture, shift and update in the same edge: capture wins over shift. update is evaluated on the SR value before that edge.
- rst_ni asserted mid-transaction: all outputs return to reset values immediately. A later response is not accepted.

Optional Feature:
Macro BSCAN_DMI_TIMEOUT_EN.
- Defined: a counter runs in REQ and WAIT_RSP and clears on entry to REQ. On reaching TIMEOUT_CYCLES: sticky=2, FSM->IDLE, dmi_req_valid_o and dmi_resp_ready_o drop the next cycle.
- Undefined: no counter; the FSM waits indefinitely and TIMEOUT_CYCLES is unused.

Test Plan:
- Write: shift 41 bits (addr=0x10, data=0xDEADBEEF, op=2), then UPDATE -> dmi_req_valid_o=1 with addr 0x10, data 0xDEADBEEF, op 2, held 3 cycles until ready. Then resp ok -> next CAPTURE/shift out gives status 0, addr 0x10.
- Read: addr=0x11, op=1; responder returns 0x12345678, resp 0 -> next capture shifts out {0x11, 0x12345678, 2'b00} LSB first on tdo_o.
- Busy: responder withholds resp; CAPTURE then UPDATE op=2 -> status 3 shifted out, no second request. After tap_reset_i pulse -> status 0 on the next capture.
- Failed: resp=2 -> subsequent capture status 2, and following updates issue no request until tap_reset_i.
- sel_i=0 with TCK toggling and shift=1 -> SR, tdo_o and DMI outputs unchanged. rst_ni pulse during REQ -> dmi_req_valid_o=0 immediately.
- With BSCAN_DMI_TIMEOUT_EN, TIMEOUT_CYCLES=16, no ready -> valid drops after 16 cycles, then capture reports status 2.
